// File: rtl/vx_warp_ibuffer_if.sv
// Decode, flush and issue-side signals of the multi-warp instruction buffer.
// The master modport is the decode/issue side; the slave modport is the buffer.
interface vx_warp_ibuffer_if #(
  parameter int unsigned ISSUE_WIDTH     = 1,
  parameter int unsigned WARPS_PER_ISSUE = 4,
  parameter int unsigned DATAW           = 128
);
  localparam int unsigned NUM_WARPS = ISSUE_WIDTH * WARPS_PER_ISSUE;
  localparam int unsigned WID_W     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int unsigned WIS_W     = (WARPS_PER_ISSUE > 1) ? $clog2(WARPS_PER_ISSUE) : 1;

  logic                         in_valid;
  logic [WID_W-1:0]             in_wid;
  logic [DATAW-1:0]             in_data;
  logic                         in_ready;
  logic                         flush_valid;
  logic [WID_W-1:0]             flush_wid;
  logic [ISSUE_WIDTH-1:0]       out_valid;
  logic [ISSUE_WIDTH*DATAW-1:0] out_data;
  logic [ISSUE_WIDTH*WIS_W-1:0] out_wis;
  logic [ISSUE_WIDTH-1:0]       out_ready;
  logic [NUM_WARPS-1:0]         pop;

  modport master (
    output in_valid, in_wid, in_data, flush_valid, flush_wid, out_ready,
    input  in_ready, out_valid, out_data, out_wis, pop
  );

  modport slave (
    input  in_valid, in_wid, in_data, flush_valid, flush_wid, out_ready,
    output in_ready, out_valid, out_data, out_wis, pop
  );
endinterface

// File: rtl/vx_warp_ibuffer.sv
// Per-warp instruction FIFOs feeding one round-robin output register per issue slot.
// Define IBUF_OCCUPANCY_EN to expose per-warp occupancy and an any_full flag.
module vx_warp_ibuffer #(
  parameter int unsigned ISSUE_WIDTH     = 1,
  parameter int unsigned WARPS_PER_ISSUE = 4,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned DATAW           = 128
) (
  input  logic              clk,
  input  logic              reset,
  vx_warp_ibuffer_if.slave  bus
`ifdef IBUF_OCCUPANCY_EN
  ,
  output logic [ISSUE_WIDTH*WARPS_PER_ISSUE*$clog2(DEPTH+1)-1:0] occupancy,
  output logic                                                    any_full
`endif
);
  localparam int unsigned NUM_WARPS = ISSUE_WIDTH * WARPS_PER_ISSUE;
  localparam int unsigned WID_W     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int unsigned WIS_W     = (WARPS_PER_ISSUE > 1) ? $clog2(WARPS_PER_ISSUE) : 1;
  localparam int unsigned ADDR_W    = $clog2(DEPTH);
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1);
  localparam int unsigned WID_SPAN  = 1 << WID_W;

  logic [DATAW-1:0]    mem    [NUM_WARPS][DEPTH];
  logic [ADDR_W-1:0]   rd_ptr [NUM_WARPS];
  logic [ADDR_W-1:0]   wr_ptr [NUM_WARPS];
  logic [CNT_W-1:0]    count  [NUM_WARPS];

  logic [WID_SPAN-1:0]  full_pad;
  logic [NUM_WARPS-1:0] nonempty, flush_hit, enq, cand, deq, pop_d;

  logic [ISSUE_WIDTH-1:0] out_valid_q;
  logic [DATAW-1:0]       out_data_q [ISSUE_WIDTH];
  logic [WIS_W-1:0]       out_wis_q  [ISSUE_WIDTH];
  logic [WIS_W-1:0]       rr_ptr     [ISSUE_WIDTH];
  logic [NUM_WARPS-1:0]   pop_q;

  logic [ISSUE_WIDTH-1:0] held_flush, load, found, hs;
  logic [WIS_W-1:0]       winner [ISSUE_WIDTH];
  logic [DATAW-1:0]       head   [ISSUE_WIDTH];

  // Unused warp ids (non power-of-two warp counts) read as full so they are never accepted.
  always_comb begin
    full_pad  = '1;
    nonempty  = '0;
    flush_hit = '0;
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      full_pad[w]  = (count[w] == CNT_W'(DEPTH));
      nonempty[w]  = (count[w] != '0);
      flush_hit[w] = bus.flush_valid && (bus.flush_wid == WID_W'(w));
    end
  end

  assign bus.in_ready = !full_pad[bus.in_wid];

  always_comb begin
    enq = '0;
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      enq[w] = bus.in_valid && !full_pad[bus.in_wid] && (bus.in_wid == WID_W'(w));
    end
    // An entry arriving at an empty FIFO may go straight to the output register.
    cand = (nonempty | enq) & ~flush_hit;
  end

  // Per-slot round-robin pick, dequeue and pop generation.
  always_comb begin
    held_flush = '0;
    load       = '0;
    found      = '0;
    hs         = '0;
    deq        = '0;
    pop_d      = '0;
    for (int unsigned s = 0; s < ISSUE_WIDTH; s++) begin
      winner[s] = '0;
      head[s]   = '0;
    end
    for (int unsigned s = 0; s < ISSUE_WIDTH; s++) begin
      for (int unsigned i = 0; i < WARPS_PER_ISSUE; i++) begin
        if (out_valid_q[s] && (out_wis_q[s] == WIS_W'(i)) && flush_hit[i*ISSUE_WIDTH+s])
          held_flush[s] = 1'b1;
      end
      hs[s]   = out_valid_q[s] && bus.out_ready[s] && !held_flush[s];
      load[s] = (!out_valid_q[s] || bus.out_ready[s]) && !held_flush[s];
      for (int unsigned o = 0; o < WARPS_PER_ISSUE; o++) begin
        for (int unsigned i = 0; i < WARPS_PER_ISSUE; i++) begin
          if (!found[s] && cand[i*ISSUE_WIDTH+s] &&
              (i == (32'(rr_ptr[s]) + o) % WARPS_PER_ISSUE)) begin
            found[s]  = 1'b1;
            winner[s] = WIS_W'(i);
          end
        end
      end
      for (int unsigned i = 0; i < WARPS_PER_ISSUE; i++) begin
        if (winner[s] == WIS_W'(i))
          head[s] = nonempty[i*ISSUE_WIDTH+s] ?
                    mem[i*ISSUE_WIDTH+s][rd_ptr[i*ISSUE_WIDTH+s]] : bus.in_data;
        deq[i*ISSUE_WIDTH+s]   = load[s] && found[s] && (winner[s] == WIS_W'(i));
        pop_d[i*ISSUE_WIDTH+s] = hs[s] && (out_wis_q[s] == WIS_W'(i));
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      if (enq[w]) mem[w][wr_ptr[w]] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        rd_ptr[w] <= '0;
        wr_ptr[w] <= '0;
        count[w]  <= '0;
      end
      for (int unsigned s = 0; s < ISSUE_WIDTH; s++) begin
        out_data_q[s] <= '0;
        out_wis_q[s]  <= '0;
        rr_ptr[s]     <= '0;
      end
      out_valid_q <= '0;
      pop_q       <= '0;
    end else begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        if (flush_hit[w]) begin
          rd_ptr[w] <= '0;
          wr_ptr[w] <= '0;
          count[w]  <= '0;
        end else begin
          if (enq[w]) wr_ptr[w] <= wr_ptr[w] + ADDR_W'(1);
          if (deq[w]) rd_ptr[w] <= rd_ptr[w] + ADDR_W'(1);
          if (enq[w] && !deq[w])      count[w] <= count[w] + CNT_W'(1);
          else if (!enq[w] && deq[w]) count[w] <= count[w] - CNT_W'(1);
        end
      end
      for (int unsigned s = 0; s < ISSUE_WIDTH; s++) begin
        if (held_flush[s]) begin
          out_valid_q[s] <= 1'b0;
        end else if (load[s]) begin
          out_valid_q[s] <= found[s];
          if (found[s]) begin
            out_data_q[s] <= head[s];
            out_wis_q[s]  <= winner[s];
            rr_ptr[s]     <= WIS_W'((32'(winner[s]) + 1) % WARPS_PER_ISSUE);
          end
        end
      end
      pop_q <= pop_d;
    end
  end

  always_comb begin
    bus.out_data = '0;
    bus.out_wis  = '0;
    for (int unsigned s = 0; s < ISSUE_WIDTH; s++) begin
      bus.out_data[s*DATAW +: DATAW] = out_data_q[s];
      bus.out_wis[s*WIS_W +: WIS_W]  = out_wis_q[s];
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.pop       = pop_q;

`ifdef IBUF_OCCUPANCY_EN
  always_comb begin
    occupancy = '0;
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      occupancy[w*CNT_W +: CNT_W] = count[w];
    end
  end

  assign any_full = |full_pad[NUM_WARPS-1:0];
`endif
endmodule

// File: tb/tb_vx_warp_ibuffer.sv
// Directed bench for vx_warp_ibuffer: one single-slot and one two-slot instance.
module tb_vx_warp_ibuffer;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  vx_warp_ibuffer_if #(.ISSUE_WIDTH(1), .WARPS_PER_ISSUE(4), .DATAW(128)) ia ();
  vx_warp_ibuffer_if #(.ISSUE_WIDTH(2), .WARPS_PER_ISSUE(4), .DATAW(32))  ib ();

`ifdef IBUF_OCCUPANCY_EN
  logic [11:0] occ_a;
  logic        full_a;
  logic [23:0] occ_b;
  logic        full_b;
`endif

  vx_warp_ibuffer #(.ISSUE_WIDTH(1), .WARPS_PER_ISSUE(4), .DEPTH(4), .DATAW(128)) u_a (
    .clk(clk), .reset(reset), .bus(ia)
`ifdef IBUF_OCCUPANCY_EN
    , .occupancy(occ_a), .any_full(full_a)
`endif
  );

  vx_warp_ibuffer #(.ISSUE_WIDTH(2), .WARPS_PER_ISSUE(4), .DEPTH(4), .DATAW(32)) u_b (
    .clk(clk), .reset(reset), .bus(ib)
`ifdef IBUF_OCCUPANCY_EN
    , .occupancy(occ_b), .any_full(full_b)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input int wid, input logic [127:0] d);
    ia.in_valid = 1'b1;
    ia.in_wid   = 2'(wid);
    ia.in_data  = d;
    step();
    ia.in_valid = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rr_wid [6];
    int rr_dat [6];
    int exp_wis [5];
    int exp_dat [5];
    rr_wid  = '{0, 0, 1, 1, 3, 3};
    rr_dat  = '{'h20, 'h21, 'h30, 'h31, 'h50, 'h51};
    exp_wis = '{1, 3, 0, 1, 3};
    exp_dat = '{'h30, 'h50, 'h21, 'h31, 'h51};

    ia.in_valid = 1'b0; ia.in_wid = '0; ia.in_data = '0;
    ia.flush_valid = 1'b0; ia.flush_wid = '0; ia.out_ready = '0;
    ib.in_valid = 1'b0; ib.in_wid = '0; ib.in_data = '0;
    ib.flush_valid = 1'b0; ib.flush_wid = '0; ib.out_ready = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_a", ia.out_valid, 0);
    check("rst_pop_a", ia.pop, 0);
    check("rst_data_a", ia.out_data, 0);
    check("rst_wis_a", ia.out_wis, 0);
    check("rst_valid_b", ib.out_valid, 0);
    reset = 1'b1;
    step();
    check("rst_ready_a", ia.in_ready, 1);

    // basic path: wid 2 straight through to the output register
    ia.out_ready = 1'b1;
    push_a(2, 'hA5);
    check("basic_valid", ia.out_valid, 1);
    check("basic_data", ia.out_data, 'hA5);
    check("basic_wis", ia.out_wis, 2);
    check("basic_pop_early", ia.pop, 0);
    step();
    check("basic_pop", ia.pop, 4'b0100);
    check("basic_valid_drop", ia.out_valid, 0);
    step();
    check("basic_pop_clear", ia.pop, 0);

    // full: first entry sits in the output register, four more fill FIFO[1]
    ia.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) push_a(1, 128'('h11 + k));
    ia.in_wid = 2'd1;
    #1;
    check("full_ready_w1", ia.in_ready, 0);
    ia.in_wid = 2'd0;
    #1;
    check("full_ready_w0", ia.in_ready, 1);
`ifdef IBUF_OCCUPANCY_EN
    check("full_occ_w1", occ_a[5:3], 4);
    check("full_any_full", full_a, 1);
`endif
    repeat (10) step();
    check("hold_valid", ia.out_valid, 1);
    check("hold_data", ia.out_data, 'h11);
    check("hold_wis", ia.out_wis, 1);
    ia.out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      step();
      check("drain_data", ia.out_data, 128'('h11 + k));
    end
    step();
    check("drain_valid_end", ia.out_valid, 0);
    check("drain_pop", ia.pop, 4'b0010);
    step();

    // round robin over wids 0, 1, 3
    ia.out_ready = 1'b0;
    for (int k = 0; k < 6; k++) push_a(rr_wid[k], 128'(rr_dat[k]));
    check("rr_first_wis", ia.out_wis, 0);
    check("rr_first_data", ia.out_data, 'h20);
    ia.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("rr_valid", ia.out_valid, 1);
      check("rr_wis", ia.out_wis, 128'(exp_wis[k]));
      check("rr_data", ia.out_data, 128'(exp_dat[k]));
    end
    step();
    check("rr_valid_end", ia.out_valid, 0);
    step();

    // flush of the warp held in the output register
    ia.out_ready = 1'b0;
    push_a(3, 'h60);
    push_a(3, 'h61);
    push_a(3, 'h62);
    push_a(2, 'h70);
    check("fl_held_wis", ia.out_wis, 3);
    ia.out_ready   = 1'b1;
    ia.flush_valid = 1'b1;
    ia.flush_wid   = 2'd3;
    step();
    ia.flush_valid = 1'b0;
    check("fl_valid_drop", ia.out_valid, 0);
    check("fl_no_pop", ia.pop, 0);
    step();
    check("fl_reload_valid", ia.out_valid, 1);
    check("fl_reload_wis", ia.out_wis, 2);
    check("fl_reload_data", ia.out_data, 'h70);
    check("fl_reload_pop", ia.pop, 0);
    step();
    check("fl_after_valid", ia.out_valid, 0);
    check("fl_after_pop", ia.pop, 4'b0100);
    step();
    check("fl_idle_valid", ia.out_valid, 0);
    check("fl_idle_pop", ia.pop, 0);

    // same-cycle enqueue and flush of wid 0
    ia.in_valid = 1'b1; ia.in_wid = 2'd0; ia.in_data = 'h99;
    ia.flush_valid = 1'b1; ia.flush_wid = 2'd0;
    #1;
    check("ef_ready", ia.in_ready, 1);
    step();
    ia.in_valid = 1'b0; ia.flush_valid = 1'b0;
    check("ef_valid", ia.out_valid, 0);
`ifdef IBUF_OCCUPANCY_EN
    check("ef_occ_w0", occ_a[2:0], 0);
`endif
    step();
    check("ef_valid_later", ia.out_valid, 0);
    check("ef_pop", ia.pop, 0);
    push_a(0, 'h9A);
    check("ef_next_data", ia.out_data, 'h9A);
    step();

    // two slots: slot 0 stalled on wid 0, wid 5 streams through slot 1
    ib.out_ready = 2'b10;
    ib.in_valid = 1'b1; ib.in_wid = 3'd0; ib.in_data = 32'hAA;
    step();
    check("b_slot0_valid", ib.out_valid, 2'b01);
    for (int k = 0; k < 6; k++) begin
      ib.in_valid = 1'b1;
      ib.in_wid   = 3'd5;
      ib.in_data  = 32'h500 + 32'(k);
      step();
      check("b_valid", ib.out_valid, 2'b11);
      check("b_data1", ib.out_data[63:32], 128'(32'h500 + 32'(k)));
      check("b_wis1", ib.out_wis[3:2], 2);
      check("b_pop5", ib.pop, (k > 0) ? 8'b0010_0000 : 8'b0);
    end
    check("b_slot0_hold", ib.out_data[31:0], 'hAA);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("b_async_valid", ib.out_valid, 0);
    check("b_async_pop", ib.pop, 0);
    ib.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    step();
    check("b_post_rst_valid", ib.out_valid, 0);
    check("b_post_rst_pop", ib.pop, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
